// File: rtl/ctrl_pkg.sv
// Shared types for the fetch/decode control path: instruction word layout,
// HALT opcode and sequencer state encoding.
package ctrl_pkg;

  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned OPERAND_W = 12;
  localparam logic [OPCODE_W-1:0] HALT_OP = 4'hF;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
  } instr_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    HALT_DRAIN,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Prefetch buffer: synchronous FIFO with a synchronous flush that overrides
// any push/pop in the same cycle. Each entry carries {instruction, address}.
module instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + {{PTR_W{1'b0}}, w_do_push} - {{PTR_W{1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch sequencer: single-outstanding imem fetch into a prefetch
// FIFO, valid/ready delivery downstream, branch redirect and HALT handling.
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_W-1:0]    imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [INSTR_W-5:0]    operand,
  output logic [ADDR_W-1:0]     pc_out,
  input  logic                  branch_taken,
  input  logic [ADDR_W-1:0]     branch_target,
  output logic                  halted,
  output logic                  busy
);

  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  seq_state_t          r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_req_addr;
  logic                r_outst;

  logic                w_run;
  logic                w_branch;
  logic                w_accept;
  logic                w_halt;
  logic                w_room;
  logic                w_new_req;
  logic                w_push;
  logic                w_flush;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [ENTRY_W-1:0]  w_head;

  assign w_run       = (r_state == RUN);
  assign instr_valid = w_run & ~w_empty;
  assign w_accept    = instr_valid & instr_ready;
  assign w_branch    = w_run & branch_taken;
  // A branch in the same cycle as HALT acceptance takes precedence.
  assign w_halt      = w_accept & (opcode == HALT_OP) & ~w_branch;
  assign w_flush     = w_branch | w_halt;

  assign w_room    = ({1'b0, w_count} + {{CNT_W{1'b0}}, r_outst}) < (CNT_W+1)'(FIFO_DEPTH);
  // New requests are suppressed in redirect/halt cycles so no stale fetch is issued.
  assign w_new_req = w_run & ~r_outst & w_room & ~w_branch & ~w_halt;
  assign imem_req  = r_outst | w_new_req;
  assign imem_addr = r_outst ? r_req_addr : r_pc;

  assign w_push = w_run & imem_req & imem_ack & ~w_flush & ~w_full;

  assign opcode  = w_head[ENTRY_W-1 -: OPCODE_W];
  assign operand = w_head[ENTRY_W-OPCODE_W-1 -: (INSTR_W-OPCODE_W)];
  assign pc_out  = w_head[ADDR_W-1:0];

  assign halted = (r_state == HALTED);
  assign busy   = (r_state == RUN) | (r_state == FLUSH) | (r_state == HALT_DRAIN);

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_accept),
    .flush (w_flush),
    .din   ({imem_rdata, imem_addr}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_req_addr <= '0;
      r_outst    <= 1'b0;
    end else begin
      r_outst <= imem_req & ~imem_ack;
      if (imem_req) begin
        r_req_addr <= imem_addr;
      end
      case (r_state)
        IDLE, HALTED: begin
          if (start) begin
            r_state <= RUN;
            r_pc    <= start_addr;
          end
        end
        RUN: begin
          if (w_branch) begin
            r_state <= FLUSH;
            r_pc    <= branch_target;
          end else if (w_halt) begin
            r_state <= HALT_DRAIN;
          end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (!r_outst || imem_ack) begin
            r_state <= RUN;
          end
        end
        HALT_DRAIN: begin
          if (!r_outst || imem_ack) begin
            r_state <= HALTED;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed per-cycle vector bench for instr_sequencer: streaming, backpressure,
// branch redirect, HALT, address wrap, mid-run reset and branch-vs-HALT priority.
module tb_instr_sequencer;
  import ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic [7:0]  pc_out;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halted;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        st;
    logic [7:0]  sa;
    logic        ack;
    logic [15:0] rd;
    logic        rdy;
    logic        br;
    logic [7:0]  bt;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_vld;
    instr_t      e_ins;
    logic [7:0]  e_pc;
    logic        e_hlt;
    logic        e_bsy;
  } vec_t;

  instr_sequencer #(
    .ADDR_W     (8),
    .INSTR_W    (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .pc_out        (pc_out),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t V(logic st, logic [7:0] sa, logic ack, logic [15:0] rd,
                             logic rdy, logic br, logic [7:0] bt,
                             logic req, logic [7:0] addr, logic vld, logic [15:0] word,
                             logic [7:0] pc, logic hlt, logic bsy);
    vec_t r;
    r.st = st; r.sa = sa; r.ack = ack; r.rd = rd; r.rdy = rdy; r.br = br; r.bt = bt;
    r.e_req = req; r.e_addr = addr; r.e_vld = vld; r.e_ins = instr_t'(word);
    r.e_pc = pc; r.e_hlt = hlt; r.e_bsy = bsy;
    return r;
  endfunction

  task automatic check_zero(input string name);
    n_checks++;
    if ({imem_req, imem_addr, instr_valid, opcode, operand, pc_out, halted, busy} !== '0) begin
      n_errors++;
      $display("FAIL %s: outputs req=%b addr=%h vld=%b op=%h oper=%h pc=%h hlt=%b busy=%b, required all 0",
               name, imem_req, imem_addr, instr_valid, opcode, operand, pc_out, halted, busy);
    end
  endtask

  // Called at posedge+1: drive inputs, check outputs at the negedge, advance one cycle.
  task automatic apply(input vec_t t, input string name);
    start = t.st; start_addr = t.sa; imem_ack = t.ack; imem_rdata = t.rd;
    instr_ready = t.rdy; branch_taken = t.br; branch_target = t.bt;
    @(negedge clk);
    n_checks++;
    if ({imem_req, imem_addr} !== {t.e_req, t.e_addr}) begin
      n_errors++;
      $display("FAIL %s fetch: req/addr=%b/%h, required %b/%h", name, imem_req, imem_addr, t.e_req, t.e_addr);
    end
    n_checks++;
    if (instr_valid !== t.e_vld ||
        (t.e_vld && ({opcode, operand, pc_out} !== {t.e_ins.opcode, t.e_ins.operand, t.e_pc}))) begin
      n_errors++;
      $display("FAIL %s downstream: vld=%b op=%h oper=%h pc=%h, required vld=%b op=%h oper=%h pc=%h",
               name, instr_valid, opcode, operand, pc_out, t.e_vld, t.e_ins.opcode, t.e_ins.operand, t.e_pc);
    end
    n_checks++;
    if ({halted, busy} !== {t.e_hlt, t.e_bsy}) begin
      n_errors++;
      $display("FAIL %s status: halted/busy=%b/%b, required %b/%b", name, halted, busy, t.e_hlt, t.e_bsy);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;

    //         st sa     ack rd       rdy br bt     req addr  vld word     pc     h  b
    tbl.push_back(V(1,'h10, 0,'h0000, 0, 0,'h00,  0,'h00, 0,'h0000,'h00, 0, 0));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'h10, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 1,'h1A10, 0, 0,'h00,  1,'h10, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'h11, 1,'h1A10,'h10, 0, 1));
    tbl.push_back(V(0,'h00, 1,'h2B11, 0, 0,'h00,  1,'h11, 1,'h1A10,'h10, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  0,'h12, 1,'h1A10,'h10, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  0,'h12, 1,'h1A10,'h10, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  0,'h12, 1,'h1A10,'h10, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h12, 1,'h2B11,'h11, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 1,'h40,  1,'h12, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h12, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 1,'h3C12, 1, 0,'h00,  1,'h12, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h40, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 1,'h4D40, 1, 0,'h00,  1,'h40, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h41, 1,'h4D40,'h40, 0, 1));
    tbl.push_back(V(0,'h00, 1,'hF000, 1, 0,'h00,  1,'h41, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'h42, 1,'hF000,'h41, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h42, 1,'hF000,'h41, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'h42, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 1,'h5555, 0, 0,'h00,  1,'h42, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  0,'h42, 0,'h0000,'h00, 1, 0));
    tbl.push_back(V(0,'h00, 1,'h9999, 0, 0,'h00,  0,'h42, 0,'h0000,'h00, 1, 0));
    tbl.push_back(V(1,'hFF, 0,'h0000, 0, 0,'h00,  0,'h42, 0,'h0000,'h00, 1, 0));
    tbl.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'hFF, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 1,'h6EFF, 0, 0,'h00,  1,'hFF, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h00, 1,'h6EFF,'hFF, 0, 1));
    tbl.push_back(V(0,'h00, 1,'h7A00, 1, 0,'h00,  1,'h00, 0,'h0000,'h00, 0, 1));
    tbl.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h01, 1,'h7A00,'h00, 0, 1));

    // After mid-run reset: idle with a stray ack, then branch-beats-HALT,
    // ignored start/branch, and ack coinciding with branch.
    seq.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  0,'h00, 0,'h0000,'h00, 0, 0));
    seq.push_back(V(0,'h00, 1,'hABCD, 0, 0,'h00,  0,'h00, 0,'h0000,'h00, 0, 0));
    seq.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  0,'h00, 0,'h0000,'h00, 0, 0));
    seq.push_back(V(1,'h20, 0,'h0000, 0, 0,'h00,  0,'h00, 0,'h0000,'h00, 0, 0));
    seq.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'h20, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(0,'h00, 1,'hF123, 0, 0,'h00,  1,'h20, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(1,'h55, 0,'h0000, 1, 1,'h80,  0,'h21, 1,'hF123,'h20, 0, 1));
    seq.push_back(V(0,'h00, 0,'h0000, 0, 1,'h33,  0,'h80, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'h80, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(0,'h00, 1,'h1111, 0, 1,'h90,  1,'h80, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  0,'h90, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(0,'h00, 0,'h0000, 0, 0,'h00,  1,'h90, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(0,'h00, 1,'h2222, 0, 0,'h00,  1,'h90, 0,'h0000,'h00, 0, 1));
    seq.push_back(V(0,'h00, 0,'h0000, 1, 0,'h00,  1,'h91, 1,'h2222,'h90, 0, 1));

    @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("stream%0d", i));
    end

    // Asynchronous reset while a request is outstanding.
    rst_n = 1'b0;
    #1;
    check_zero("reset_midrun");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < seq.size(); i++) begin
      apply(seq[i], $sformatf("corner%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
